// File: rtl/ppu_fetch_unit_if.sv
// Fetch-stage bundle: instruction-memory request channel plus the IF/ID handoff to decode.
// The fetch unit takes the master side; memory and decode together form the slave side.
interface ppu_fetch_unit_if #(
    parameter int IMEM_AW = 9
);
    logic               imem_req;
    logic [IMEM_AW-1:0] imem_addr;
    logic               imem_ack;
    logic [31:0]        imem_rdata;
    logic               id_valid;
    logic [31:0]        id_instr;
    logic [31:0]        id_pc;
    logic               id_stall;
    logic               redirect;
    logic [31:0]        redirect_target;

    modport master (
        output imem_req, imem_addr, id_valid, id_instr, id_pc,
        input  imem_ack, imem_rdata, id_stall, redirect, redirect_target
    );

    modport slave (
        input  imem_req, imem_addr, id_valid, id_instr, id_pc,
        output imem_ack, imem_rdata, id_stall, redirect, redirect_target
    );
endinterface

// File: rtl/ppu_fetch_unit.sv
// PPU instruction fetch: single-outstanding imem requests, IF/ID register with a one-entry skid,
// and delay-slot redirect handling (the delay slot is always fetched before the target).
module ppu_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IMEM_AW  = 9
) (
    input  logic clk,
    input  logic reset_n,
    ppu_fetch_unit_if.master fetch_if
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

    state_e      state_q,     state_d;
    logic        req_q,       req_d;
    logic [31:0] fpc_q,       fpc_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_instr_q, out_instr_d;
    logic [31:0] out_pc_q,    out_pc_d;
    logic        sk_valid_q,  sk_valid_d;
    logic [31:0] sk_instr_q,  sk_instr_d;
    logic [31:0] sk_pc_q,     sk_pc_d;
    logic [31:0] tgt_q,       tgt_d;
    logic        redir_pend_q, redir_pend_d;

    logic        consume_s;
    logic        ret_s;
    logic        out_take_s;
    logic        redir_s;
    logic [31:0] target_s;

    assign consume_s  = out_valid_q && !fetch_if.id_stall;
    assign ret_s      = req_q && fetch_if.imem_ack;
    assign out_take_s = ret_s && (!out_valid_q || consume_s);
    assign redir_s    = consume_s && fetch_if.redirect;
    assign target_s   = fetch_if.redirect_target & 32'hFFFF_FFFC;

    // Next-state computation for the fetch FSM, PC, IF/ID register, skid and pending redirect
    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        fpc_d        = fpc_q;
        out_valid_d  = out_valid_q;
        out_instr_d  = out_instr_q;
        out_pc_d     = out_pc_q;
        sk_valid_d   = sk_valid_q;
        sk_instr_d   = sk_instr_q;
        sk_pc_d      = sk_pc_q;
        tgt_d        = tgt_q;
        redir_pend_d = redir_pend_q;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
                req_d   = 1'b1;
            end
            ST_FETCH: begin
                if (ret_s && !out_take_s) begin
                    state_d    = ST_HOLD;
                    req_d      = 1'b0;
                    sk_valid_d = 1'b1;
                    sk_instr_d = fetch_if.imem_rdata;
                    sk_pc_d    = fpc_q;
                end else begin
                    // After a skid drain the request comes back one cycle late: the bubble.
                    req_d = 1'b1;
                end
            end
            ST_HOLD: begin
                req_d = 1'b0;
                if (consume_s) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
            end
        endcase

        if (out_take_s) begin
            out_valid_d = 1'b1;
            out_instr_d = fetch_if.imem_rdata;
            out_pc_d    = fpc_q;
        end else if (consume_s && sk_valid_q) begin
            out_valid_d = 1'b1;
            out_instr_d = sk_instr_q;
            out_pc_d    = sk_pc_q;
            sk_valid_d  = 1'b0;
            sk_instr_d  = 32'h0000_0000;
            sk_pc_d     = 32'h0000_0000;
        end else if (consume_s) begin
            out_valid_d = 1'b0;
            out_instr_d = 32'h0000_0000;
            out_pc_d    = 32'h0000_0000;
        end else begin
            out_valid_d = out_valid_q;
        end

        if (ret_s) begin
            fpc_d        = redir_pend_q ? tgt_q : (fpc_q + 32'd4);
            redir_pend_d = 1'b0;
        end else begin
            fpc_d = fpc_q;
        end

        // The delay slot is either already held (skid or returning now) or still being fetched.
        if (redir_s) begin
            if (sk_valid_q || ret_s) begin
                fpc_d = target_s;
            end else begin
                tgt_d        = target_s;
                redir_pend_d = 1'b1;
            end
        end else begin
            tgt_d = tgt_q;
        end
    end

    // State registers with asynchronous reset that abandons any outstanding request
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            req_q        <= 1'b0;
            fpc_q        <= RESET_PC;
            out_valid_q  <= 1'b0;
            out_instr_q  <= 32'h0000_0000;
            out_pc_q     <= 32'h0000_0000;
            sk_valid_q   <= 1'b0;
            sk_instr_q   <= 32'h0000_0000;
            sk_pc_q      <= 32'h0000_0000;
            tgt_q        <= 32'h0000_0000;
            redir_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            fpc_q        <= fpc_d;
            out_valid_q  <= out_valid_d;
            out_instr_q  <= out_instr_d;
            out_pc_q     <= out_pc_d;
            sk_valid_q   <= sk_valid_d;
            sk_instr_q   <= sk_instr_d;
            sk_pc_q      <= sk_pc_d;
            tgt_q        <= tgt_d;
            redir_pend_q <= redir_pend_d;
        end
    end

    assign fetch_if.imem_req  = req_q;
    assign fetch_if.imem_addr = fpc_q[IMEM_AW-1:0];
    assign fetch_if.id_valid  = out_valid_q;
    assign fetch_if.id_instr  = out_instr_q;
    assign fetch_if.id_pc     = out_pc_q;
endmodule

// File: tb/tb_ppu_fetch_unit.sv
// Directed bench for ppu_fetch_unit: small wait-state memory model, hand-computed PC/word sequences.
module tb_ppu_fetch_unit;
    logic       clk;
    logic       reset_n;
    int         nwait;
    int         wcnt;
    int         n_checks;
    int         n_pass;

    ppu_fetch_unit_if #(.IMEM_AW(9)) bus ();

    ppu_fetch_unit #(.RESET_PC(32'h0000_0000), .IMEM_AW(9)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .fetch_if (bus)
    );

    function automatic logic [31:0] mem_word(input logic [8:0] a);
        case (a)
            9'd0:    mem_word = 32'h0000_0011;
            9'd4:    mem_word = 32'h0000_0022;
            9'd8:    mem_word = 32'h0000_0033;
            9'd12:   mem_word = 32'h0000_0044;
            default: mem_word = 32'hC000_0000 | {23'd0, a};
        endcase
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.imem_ack   = bus.imem_req && (wcnt == nwait);
    assign bus.imem_rdata = mem_word(bus.imem_addr);

    // Wait-state counter of the memory model
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) wcnt <= 0;
        else if (bus.imem_req && !bus.imem_ack) wcnt <= wcnt + 1;
        else wcnt <= 0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
        else n_pass = n_pass + 1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench in cycle 1 (first cycle after the first edge with reset_n high)
    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic wait_pc(input string tag, input logic [31:0] pc, input int max);
        logic found;
        found = 1'b0;
        for (int i = 0; i < max && !found; i++) begin
            tick();
            if (bus.id_valid && bus.id_pc == pc) found = 1'b1;
        end
        chk(tag, {31'd0, found}, 32'd1);
    endtask

    task automatic branch_zw(input logic [31:0] tgt, input logic [31:0] pc1, input logic [31:0] w1,
                             input logic [31:0] pc2, input logic [31:0] w2);
        nwait = 0;
        do_reset();
        tick();
        tick();
        tick();
        chk("zw_pc8", bus.id_pc, 32'd8);
        bus.redirect = 1'b1;
        bus.redirect_target = tgt;
        tick();
        bus.redirect = 1'b0;
        chk("zw_slot_pc", bus.id_pc, 32'd12);
        chk("zw_slot_w", bus.id_instr, 32'h0000_0044);
        chk("zw_addr_tgt", {23'd0, bus.imem_addr}, {23'd0, pc1[8:0]});
        tick();
        chk("zw_tgt_pc", bus.id_pc, pc1);
        chk("zw_tgt_w", bus.id_instr, w1);
        tick();
        chk("zw_next_pc", bus.id_pc, pc2);
        chk("zw_next_w", bus.id_instr, w2);
    endtask

    task automatic branch_2w(input logic [31:0] tgt);
        nwait = 2;
        do_reset();
        wait_pc("w2_reach8", 32'd8, 40);
        bus.redirect = 1'b1;
        bus.redirect_target = tgt;
        tick();
        bus.redirect = 1'b0;
        for (int i = 0; i < 10 && !bus.id_valid; i++) begin
            chk("w2_addr_hold", {23'd0, bus.imem_addr}, 32'd12);
            tick();
        end
        chk("w2_slot_pc", bus.id_pc, 32'd12);
        chk("w2_addr_tgt", {23'd0, bus.imem_addr}, 32'h0000_0040);
        wait_pc("w2_reach_tgt", 32'h0000_0040, 10);
        chk("w2_tgt_w", bus.id_instr, 32'hC000_0040);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        nwait    = 0;
        reset_n  = 1'b0;
        bus.id_stall = 1'b0;
        bus.redirect = 1'b0;
        bus.redirect_target = 32'h0000_0000;

        // Reset and stream, then stall into the skid
        tick();
        tick();
        chk("rst_req", {31'd0, bus.imem_req}, 32'd0);
        chk("rst_valid", {31'd0, bus.id_valid}, 32'd0);
        chk("rst_pc", bus.id_pc, 32'd0);
        chk("rst_instr", bus.id_instr, 32'd0);
        chk("rst_addr", {23'd0, bus.imem_addr}, 32'd0);
        reset_n = 1'b1;
        tick();
        chk("c1_req", {31'd0, bus.imem_req}, 32'd1);
        chk("c1_valid", {31'd0, bus.id_valid}, 32'd0);
        tick();
        chk("c2_valid", {31'd0, bus.id_valid}, 32'd1);
        chk("c2_pc", bus.id_pc, 32'd0);
        chk("c2_w", bus.id_instr, 32'h0000_0011);
        tick();
        chk("c3_pc", bus.id_pc, 32'd4);
        chk("c3_w", bus.id_instr, 32'h0000_0022);
        bus.id_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_pc", bus.id_pc, 32'd4);
            chk("stall_req", {31'd0, bus.imem_req}, 32'd0);
        end
        bus.id_stall = 1'b0;
        tick();
        chk("drain_pc", bus.id_pc, 32'd8);
        chk("drain_w", bus.id_instr, 32'h0000_0033);
        tick();
        chk("bubble_valid", {31'd0, bus.id_valid}, 32'd0);
        chk("bubble_instr", bus.id_instr, 32'd0);
        chk("bubble_addr", {23'd0, bus.imem_addr}, 32'd12);
        tick();
        chk("after_pc", bus.id_pc, 32'd12);
        chk("after_w", bus.id_instr, 32'h0000_0044);

        // Zero-wait branch, and a branch whose target wraps the PC
        branch_zw(32'h0000_0040, 32'h0000_0040, 32'hC000_0040, 32'h0000_0044, 32'hC000_0044);
        branch_zw(32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'hC000_01FC, 32'h0000_0000, 32'h0000_0011);

        // Two-wait memory: aligned and misaligned redirect targets
        branch_2w(32'h0000_0040);
        branch_2w(32'h0000_0043);

        // Reset while a request is outstanding
        chk("mid_req_before", {31'd0, bus.imem_req}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("mid_req", {31'd0, bus.imem_req}, 32'd0);
        chk("mid_valid", {31'd0, bus.id_valid}, 32'd0);
        chk("mid_instr", bus.id_instr, 32'd0);
        chk("mid_addr", {23'd0, bus.imem_addr}, 32'd0);
        tick();
        reset_n = 1'b1;
        tick();
        chk("restart_req", {31'd0, bus.imem_req}, 32'd1);
        chk("restart_addr", {23'd0, bus.imem_addr}, 32'd0);
        wait_pc("restart_pc0", 32'd0, 10);
        chk("restart_w", bus.id_instr, 32'h0000_0011);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
